// File: rtl/mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with a word-addressed
//               storage array, byte-lane store masking and a fixed,
//               parameterised request-to-response latency.
// Revision    : 1.0 - initial release
//============================================================================
module mem_responder #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wmask,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int         C_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY     = 2'd1;
    localparam logic [1:0] S_RESP     = 2'd2;
    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic            write_q, write_d;
    logic [XLEN-1:0] addr_q,  addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q,   err_d;

    // Storage is deliberately left without reset.
    logic [XLEN-1:0] mem [C_DEPTH];

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oor;
    logic                  w_commit;

    assign w_idx    = addr_q[DEPTH_LOG2+1:2];
    assign w_oor    = |addr_q[XLEN-1:DEPTH_LOG2+2];
    assign w_commit = (state_q == S_BUSY) && (cnt_q == 4'd0);

    // Next-state logic: latch request in IDLE, count down in BUSY, hold in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = C_CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    err_d   = w_oor;
                    rdata_d = (w_oor || write_q) ? '0 : mem[w_idx];
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage update: masked byte-lane write at the commit cycle of a store.
    always_ff @(posedge clk) begin
        if (w_commit && write_q && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // req_ready is gated by reset so it reads 0 while reset is held.
    assign req_ready  = rst && (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_mem_responder
// Description : Randomised self-checking bench for mem_responder; three
//               instances with LATENCY 2, 1 and 15 against a word-array model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_wmask  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    int          n_chk;
    int          n_fail;
    logic [31:0] model    [NI][16];
    time         last_acc [NI];

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            mem_responder #(
                .XLEN       (32),
                .DEPTH_LOG2 (10),
                .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_write  (req_write[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .req_wmask  (req_wmask[g]),
                .resp_valid (resp_valid[g]),
                .resp_ready (resp_ready[g]),
                .resp_rdata (resp_rdata[g]),
                .resp_err   (resp_err[g])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on instance k with bp cycles of response stall.
    // When b2b is set the previous transaction ended with no stall, so the
    // accept spacing must be exactly LATENCY+2 cycles.
    task automatic xact(input int k, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input int bp, input bit b2b, input string tag);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          idx;
        int          lat;
        time         t_acc;
        exp_err = (a >> 12) != 0;
        idx     = int'((a >> 2) & 32'hF);
        check_eq({tag, "_rdy"}, 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = d;
        req_wmask[k] = m;
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid[k] = 1'b0;
        req_write[k] = 1'b1;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_wmask[k] = 4'hF;
        if (b2b)
            check_eq({tag, "_b2b"}, 32'(t_acc - last_acc[k]), 32'((lat_of(k) + 2) * 10));
        last_acc[k] = t_acc;

        exp_rd = 32'd0;
        if (!exp_err && !wr) exp_rd = model[k][idx];
        if (!exp_err && wr) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) model[k][idx][8*i +: 8] = d[8*i +: 8];
        end

        lat = 0;
        while (resp_valid[k] !== 1'b1 && lat < 20) begin
            check_eq({tag, "_busy_rdy"}, 32'(req_ready[k]), 32'd0);
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(lat_of(k)));
        check_eq({tag, "_err"}, 32'(resp_err[k]), 32'(exp_err));
        check_eq({tag, "_rdata"}, resp_rdata[k], exp_rd);

        for (int i = 0; i < bp; i++) begin
            req_valid[k] = 1'b1;
            tick();
            check_eq({tag, "_bp_valid"}, 32'(resp_valid[k]), 32'd1);
            check_eq({tag, "_bp_rdata"}, resp_rdata[k], exp_rd);
            check_eq({tag, "_bp_err"}, 32'(resp_err[k]), 32'(exp_err));
            check_eq({tag, "_bp_rdy"}, 32'(req_ready[k]), 32'd0);
        end
        resp_ready[k] = 1'b1;
        tick();
        resp_ready[k] = 1'b0;
        req_valid[k]  = 1'b0;
        check_eq({tag, "_post_valid"}, 32'(resp_valid[k]), 32'd0);
        check_eq({tag, "_post_rdy"}, 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        int          prev_bp;
        int          bp;
        logic [31:0] a;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req_valid[k]  = 1'b0;
            req_write[k]  = 1'b0;
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            req_wmask[k]  = 4'd0;
            resp_ready[k] = 1'b0;
            last_acc[k]   = 0;
        end
        tick();
        tick();
        for (int k = 0; k < NI; k++) begin
            check_eq("rst_rdy", 32'(req_ready[k]), 32'd0);
            check_eq("rst_valid", 32'(resp_valid[k]), 32'd0);
            check_eq("rst_rdata", resp_rdata[k], 32'd0);
            check_eq("rst_err", 32'(resp_err[k]), 32'd0);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++)
            check_eq("rel_rdy", 32'(req_ready[k]), 32'd1);

        // Define the 16 modelled words on every instance, back to back.
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 16; i++)
                xact(k, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, i > 0, "init");

        // Directed scenarios on the LATENCY=2 instance.
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "st10");
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, "ld10");
        xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b1, "st_part");
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b1, "ld_part");
        xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 1'b1, "st_nomask");
        xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 5, 1'b1, "ld_bp");
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, "ld_oor");
        xact(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 0, 1'b1, "st_oor");
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b1, "ld_w0");

        // Randomised traffic on all instances.
        for (int k = 0; k < NI; k++) begin
            prev_bp = 1;
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(7, 0) == 0)
                    a = {20'($urandom_range(32'hFFFFF, 1)), 12'($urandom)};
                else
                    a = 32'($urandom_range(15, 0) * 4 + $urandom_range(3, 0));
                bp = ($urandom_range(2, 0) == 0) ? $urandom_range(4, 1) : 0;
                xact(k, 1'($urandom), a, $urandom, 4'($urandom), bp, prev_bp == 0, "rnd");
                prev_bp = bp;
            end
        end

        // Reset while a store is in flight: the store must be dropped.
        for (int k = 0; k < NI; k++) begin
            xact(k, 1'b1, 32'h20, 32'hAAAA5555, 4'hF, 0, 1'b0, "st20");
            xact(k, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b1, "ld20");
        end
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b1;
            req_write[k] = 1'b1;
            req_addr[k]  = 32'h20;
            req_wdata[k] = 32'h12345678;
            req_wmask[k] = 4'hF;
        end
        tick();
        for (int k = 0; k < NI; k++) req_valid[k] = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq("mid_rdy", 32'(req_ready[k]), 32'd0);
            check_eq("mid_valid", 32'(resp_valid[k]), 32'd0);
            check_eq("mid_rdata", resp_rdata[k], 32'd0);
            check_eq("mid_err", 32'(resp_err[k]), 32'd0);
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq("mid_rel_rdy", 32'(req_ready[k]), 32'd1);
            xact(k, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "ld20_after");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
